// File: rtl/led_seq_ctrl.sv
// LED position sequencer: prescaled or manual stepping of a 3-bit position code
// in up, down, ping-pong or hold mode, with a one-cycle strobe per position change.
module led_seq_ctrl #(
  parameter int unsigned CNT_MAX = 24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       run,
  input  logic [1:0] dir_mode,
  input  logic       step_req,
  output logic [2:0] sel,
  output logic       step_pulse,
  output logic       pp_dir
);

  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             advance;
  logic [2:0]       sel_nxt;
  logic             pp_nxt;
  logic             pulse_nxt;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: the run level alone selects the state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run)  state_nxt = S_RUN;
      S_RUN:   if (!run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Advance event and prescaler next value; a step_req coinciding with run is dropped
  always_comb begin
    advance = 1'b0;
    cnt_nxt = '0;
    case (state)
      S_IDLE: begin
        advance = step_req && !run;
      end
      S_RUN: begin
        advance = (cnt == CNT_TOP);
        if (run && (cnt != CNT_TOP)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        advance = 1'b0;
        cnt_nxt = '0;
      end
    endcase
  end

  // Position update; ping-pong bounces off the ends without repeating them
  always_comb begin
    sel_nxt = sel;
    pp_nxt  = (dir_mode == MODE_PP) ? pp_dir : 1'b0;
    if (advance) begin
      case (dir_mode)
        MODE_UP:   sel_nxt = sel + 3'd1;
        MODE_DOWN: sel_nxt = sel - 3'd1;
        MODE_PP: begin
          if (!pp_dir) begin
            if (sel == 3'd7) begin
              sel_nxt = 3'd6;
              pp_nxt  = 1'b1;
            end else begin
              sel_nxt = sel + 3'd1;
            end
          end else begin
            if (sel == 3'd0) begin
              sel_nxt = 3'd1;
              pp_nxt  = 1'b0;
            end else begin
              sel_nxt = sel - 3'd1;
            end
          end
        end
        default:   sel_nxt = sel;
      endcase
    end
    pulse_nxt = advance && (sel_nxt != sel);
  end

  // Datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt        <= '0;
      sel        <= 3'd0;
      pp_dir     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      pp_dir     <= pp_nxt;
      step_pulse <= pulse_nxt;
    end
  end

endmodule
